// File: rtl/qmult_seq.sv
// qmult_seq: sequential shift-add multiplier for sign-magnitude (Q,N) fixed-point operands
// Ports: i_clk/i_rst_n clock and async active-low reset; i_multiplicand/i_multiplier operands;
// i_start request (sampled while idle); o_result product held between operations;
// o_complete idle/finished flag; o_overflow saturation flag of the last product.
module qmult_seq #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    input  logic         i_start,
    output logic [N-1:0] o_result,
    output logic         o_complete,
    output logic         o_overflow
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 2);
    typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;
    state_t state_q, state_d;
    logic [2*N-3:0] a_q, a_d, acc_q, acc_d, sh;
    logic [N-2:0] b_q, b_d, mag;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] result_q, result_d;
    logic sign_q, sign_d, overflow_q, overflow_d, start, run, fin, ovf;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE)  ? (i_start ? RUN : IDLE) :
                  (state_q == RUN)   ? ((cnt_q == LAST) ? FINAL : RUN) : IDLE;
    end
    always_comb begin
        o_complete = state_q == IDLE;
        o_result   = result_q;
        o_overflow = overflow_q;
    end
    // shifting the accumulator down by Q lets the overflow test and truncation share one view
    always_comb begin
        start      = (state_q == IDLE) && i_start;
        run        = state_q == RUN;
        fin        = state_q == FINAL;
        sh         = acc_q >> Q;
        ovf        = |sh[2*N-3:N-1];
        mag        = ovf ? '1 : sh[N-2:0];
        a_d        = start ? {{(N-1){1'b0}}, i_multiplicand[N-2:0]} : run ? a_q << 1 : a_q;
        b_d        = start ? i_multiplier[N-2:0] : run ? b_q >> 1 : b_q;
        acc_d      = start ? '0 : (run && b_q[0]) ? acc_q + a_q : acc_q;
        cnt_d      = start ? '0 : run ? cnt_q + CW'(1) : cnt_q;
        sign_d     = start ? i_multiplicand[N-1] ^ i_multiplier[N-1] : sign_q;
        result_d   = fin ? {sign_q & (|mag), mag} : result_q;
        overflow_d = fin ? ovf : start ? 1'b0 : overflow_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_qmult_seq.sv
// tb_qmult_seq: scoreboard bench for qmult_seq with directed Q15/N32 vectors
module tb_qmult_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        start;
    logic [31:0] o_result;
    logic        o_complete, o_overflow;
    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    logic [32:0] sb[$];
    qmult_seq #(.Q(15), .N(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_multiplicand(a), .i_multiplier(b),
        .i_start(start), .o_result(o_result), .o_complete(o_complete), .o_overflow(o_overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    logic prev_c = 1'b1;
    int   busy = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_c = 1'b1;
            busy = 0;
        end else begin
            if (!o_complete) busy++;
            else if (!prev_c) begin
                if (sb.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
                else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    check("result", o_result, e[31:0]);
                    check("overflow", {31'd0, o_overflow}, {31'd0, e[32]});
                    check("busy_cycles", busy, 32);
                end
                busy = 0;
            end
            prev_c = o_complete;
        end
    end
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                         input logic ov, input bit hold);
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back({ov, r});
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask
    task automatic wait_done();
        int n = 0;
        while (!o_complete && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_complete) check("timeout", {31'd0, o_complete}, 32'd1);
    endtask
    initial begin
        int t0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset_complete", {31'd0, o_complete}, 32'd1);
        check("reset_result", o_result, 32'd0);
        check("reset_overflow", {31'd0, o_overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'h0000C000, 32'h00010000, 32'h00018000, 1'b0, 1'b0); wait_done();
        issue(32'h8000C000, 32'h00010000, 32'h80018000, 1'b0, 1'b0); wait_done();
        issue(32'h8000C000, 32'h80010000, 32'h00018000, 1'b0, 1'b0); wait_done();
        issue(32'h40000000, 32'h00010000, 32'h7FFFFFFF, 1'b1, 1'b0); wait_done();
        issue(32'h00008000, 32'h00008000, 32'h00008000, 1'b0, 1'b0); wait_done();
        issue(32'h00000001, 32'h80000001, 32'h00000000, 1'b0, 1'b0); wait_done();
        issue(32'h80000000, 32'h00010000, 32'h00000000, 1'b0, 1'b0); wait_done();
        issue(32'h0000C000, 32'h00010000, 32'h00018000, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        a = 32'h00018000;
        b = 32'h00018000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) begin
            @(negedge clk);
            check("no_queued_start", {31'd0, o_complete}, 32'd1);
        end
        issue(32'h00018000, 32'h00004000, 32'h0000C000, 1'b0, 1'b1);
        sb.push_back({1'b0, 32'h0000C000});
        wait_done();
        t0 = cyc;
        @(negedge clk);
        wait_done();
        start = 1'b0;
        check("back_to_back_period", cyc - t0, 33);
        issue(32'h0000C000, 32'h00010000, 32'h00018000, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_complete", {31'd0, o_complete}, 32'd1);
        check("abort_result", o_result, 32'd0);
        check("abort_overflow", {31'd0, o_overflow}, 32'd0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'h00018000, 32'h00004000, 32'h0000C000, 1'b0, 1'b0); wait_done();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/qmult_seq.md
# qmult_seq

Sequential fixed-point multiplier for sign-magnitude (Q,N) operands, the companion to the iterative (Q,N) divider in the k-means datapath. It computes one product per `i_start` using one shift-add iteration per magnitude bit. It uses the same `i_start`/`o_complete` handshake as the divider, so the control FSM can drive either unit. Results are truncated toward zero. On overflow the result saturates and `o_overflow` is flagged.

## Interface
- `Q`, default 15: number of fractional bits.
- `N`, default 32: total word width; bit N-1 is the sign and bits N-2:0 are the magnitude.
- `i_clk`, input, 1: clock; all state updates on its rising edge.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_multiplicand`, input, N: sign-magnitude operand A.
- `i_multiplier`, input, N: sign-magnitude operand B.
- `i_start`, input, 1: request; sampled only while `o_complete`=1.
- `o_result`, output, N: sign-magnitude product; held between operations.
- `o_complete`, output, 1: high when idle or finished; low while busy.
- `o_overflow`, output, 1: high when the last product exceeded the magnitude range.

## Operation
- States:
  - IDLE (`o_complete`=1).
  - RUN (`o_complete`=0).
  - FINAL (`o_complete`=0).
- IDLE→RUN on `i_start`=1. On that edge:
  - latch A magnitude into a (2N-2)-bit shift register, zero-extended;
  - latch B magnitude into an (N-1)-bit register;
  - latch sign = A[N-1]^B[N-1];
  - clear the accumulator (2N-2 bits) and the iteration counter;
  - clear `o_overflow`.
- `o_result` is not modified on start. It keeps the previous value until FINAL.
- RUN performs one iteration per edge, N-1 iterations total:
  - if B register bit 0 = 1, accumulator += A register;
  - then A register <<= 1 and B register >>= 1;
  - counter increments.
- After iteration N-1 completes, go to FINAL.
- FINAL (one edge), then return to IDLE:
  - overflow = |acc[2N-3:N-1+Q];
  - magnitude = overflow ? all ones (N-1 bits) : acc[N-2+Q:Q], which truncates the low Q bits;
  - sign bit = sign & (magnitude != 0), so no negative zero is produced;
  - register `o_result` and `o_overflow`, and set `o_complete`=1.
- Arithmetic width rules:
  - the product of two (N-1)-bit magnitudes fits in 2N-2 bits, so the accumulator never wraps;
  - no rounding is applied.
- Requires Q ≤ N-2.

## Timing
- Reset values: `o_result`=0, `o_complete`=1, `o_overflow`=0, state IDLE, all internal registers 0.
- Start accepted at edge E0:
  - `o_complete` is low after E0;
  - iterations occur at edges E1..E(N-1);
  - FINAL is at edge EN, after which `o_result`, `o_overflow` and `o_complete`=1 are valid.
- Busy time is exactly N cycles (32 for the default N).
- Operands are captured at E0 only. Later changes on the inputs do not affect the running operation.
- `i_start` while busy (RUN or FINAL) is ignored. It is not queued.
- `i_start` on the same edge that `o_complete` rises is ignored, because the FSM is still in FINAL.
- Back-to-back operation: a start is accepted on the first edge where `o_complete`=1, so throughput is one product per N+1 cycles.
- `i_start` held high continuously: a new operation starts each time the FSM reaches IDLE.
- Reset asserted mid-operation: all outputs return to their reset values immediately and the operation is discarded. After `i_rst_n` deasserts, the block is in IDLE and accepts `i_start` on the next edge.

## Test plan
All scenarios use Q=15, N=32.
- 1.5 × 2.0: A=0x0000C000, B=0x00010000 → `o_result`=0x00018000, `o_overflow`=0, `o_complete` low for exactly 32 cycles.
- Sign handling:
  - A=0x8000C000 (−1.5), B=0x00010000 → 0x80018000;
  - A=0x8000C000, B=0x80010000 → 0x00018000.
- Overflow saturation: A=0x40000000 (32768.0), B=0x00010000 (2.0) → `o_result`=0x7FFFFFFF, `o_overflow`=1. A following 1.0×1.0 (0x00008000×0x00008000) → 0x00008000 with `o_overflow`=0.
- Truncation and zero sign:
  - 0x00000001 × 0x80000001 → 0x00000000 (no negative zero), `o_overflow`=0;
  - 0x80000000 × 0x00010000 → 0x00000000.
- Handshake:
  - pulse `i_start` with new operands at cycle 5 of a running operation → ignored, and the first result is unchanged;
  - hold `i_start` high → products are back-to-back every 33 cycles.
- Reset mid-operation: assert `i_rst_n`=0 at cycle 10 of a run → immediately `o_complete`=1, `o_result`=0, `o_overflow`=0. After release, 3.0 × 0.5 (0x00018000 × 0x00004000) → 0x0000C000.
